// File: rtl/key_cmd_encoder_pkg.sv
// Shared definitions for the key command encoder: FSM states, the idle
// command code and a small constant helper used for timer sizing.
package keyproc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } fsm_state_e;

   localparam int unsigned CMD_NONE = 0;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_cmd_encoder_if.sv
// Command handshake bundle between the encoder (master) and its consumer.
interface key_cmd_if #(
   parameter int unsigned CMD_W = 3
);

   logic [CMD_W-1:0] cmd;
   logic             cmd_valid;
   logic             cmd_ready;

   modport master (output cmd, output cmd_valid, input cmd_ready);
   modport slave  (input cmd, input cmd_valid, output cmd_ready);

endinterface

// File: rtl/key_cmd_encoder_debounce.sv
// Two-flop synchroniser followed by a stability counter; the output only
// follows the input after DEBOUNCE_CYCLES consecutive differing samples.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic sysclk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         sync <= '0;
         cnt  <= '0;
         dout <= 1'b0;
      end else begin
         sync <= {sync[0], din};
         if (sync[1] == dout) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            dout <= sync[1];
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_cmd_encoder.sv
// Debounced key pad to command encoder with auto-repeat and a single-entry
// valid/ready output register; the auto-mode switch is debounced alongside.
module key_cmd_encoder
   import keyproc_pkg::*;
#(
   parameter int unsigned NUM_KEYS        = 4,
   parameter int unsigned CMD_W           = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_RATE     = 5000000
) (
   input  logic                sysclk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] keys,
   input  logic                auto_key,
   key_cmd_if.master           cmd_bus,
   output logic                auto_switch,
   output logic [NUM_KEYS-1:0] key_state
);

   localparam int unsigned IW   = $clog2(NUM_KEYS);
   localparam int unsigned TMAX = max2(REPEAT_DELAY, REPEAT_RATE);
   localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   fsm_state_e       state, state_nxt;
   logic [IW-1:0]    act_idx, held_idx, held_nxt;
   logic             act_any, released, ev;
   logic [TW-1:0]    timer, timer_nxt;
   logic [CMD_W-1:0] ev_code, cmd_q;
   logic             valid_q;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .sysclk(sysclk), .rst(rst), .din(keys[i]), .dout(key_state[i])
      );
   end

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_auto (
      .sysclk(sysclk), .rst(rst), .din(auto_key), .dout(auto_switch)
   );

   // Highest asserted index wins.
   always_comb begin
      act_any = 1'b0;
      act_idx = '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
         if (key_state[i]) begin
            act_any = 1'b1;
            act_idx = IW'(i);
         end
      end
   end

   // A different key taking priority counts as a release of the held one.
   assign released = !act_any || (act_idx != held_idx);
   assign ev_code  = CMD_W'(held_nxt) + CMD_W'(1);

   always_comb begin
      state_nxt = state;
      held_nxt  = held_idx;
      timer_nxt = timer;
      ev        = 1'b0;
      unique case (state)
         IDLE: begin
            if (act_any) begin
               ev        = 1'b1;
               held_nxt  = act_idx;
               timer_nxt = '0;
               state_nxt = DELAY;
            end
         end
         DELAY: begin
            if (released) begin
               state_nxt = IDLE;
            end else if (timer == TW'(REPEAT_DELAY - 1)) begin
               ev        = 1'b1;
               timer_nxt = '0;
               state_nxt = REPEAT;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         REPEAT: begin
            if (released) begin
               state_nxt = IDLE;
            end else if (timer == TW'(REPEAT_RATE - 1)) begin
               ev        = 1'b1;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         held_idx <= '0;
         timer    <= '0;
         cmd_q    <= CMD_W'(CMD_NONE);
         valid_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         held_idx <= held_nxt;
         timer    <= timer_nxt;
         // Events arriving while a command is stalled are dropped.
         if (ev && (!valid_q || cmd_bus.cmd_ready)) begin
            cmd_q   <= ev_code;
            valid_q <= 1'b1;
         end else if (valid_q && cmd_bus.cmd_ready) begin
            cmd_q   <= CMD_W'(CMD_NONE);
            valid_q <= 1'b0;
         end
      end
   end

   assign cmd_bus.cmd       = cmd_q;
   assign cmd_bus.cmd_valid = valid_q;

endmodule
